// File: rtl/data_ram.sv
// data_ram: true dual-port word RAM with per-byte write enables.
// Both ports are read-first with a registered output; a same-word, same-byte
// write collision resolves in favour of port A. Memory and output registers
// power up to zero; rst clears only the output registers.
module data_ram #(
   parameter int unsigned ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  wea,
   input  logic [31:2] addra,
   input  logic [31:0] dina,
   output logic [31:0] douta,
   input  logic [3:0]  web,
   input  logic [31:2] addrb,
   input  logic [31:0] dinb,
   output logic [31:0] doutb
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   // Power-up contents come from the declaration initialisers (bitstream init).
   logic [31:0] r_mem [0:DEPTH-1] = '{default: '0};
   logic [31:0] r_douta = '0;
   logic [31:0] r_doutb = '0;

   logic [ADDR_BITS-1:0] w_idx_a;
   logic [ADDR_BITS-1:0] w_idx_b;
   logic                 w_unused_addr;

   // Only the low word-address bits are decoded; the rest wrap.
   assign w_idx_a       = addra[ADDR_BITS+1:2];
   assign w_idx_b       = addrb[ADDR_BITS+1:2];
   assign w_unused_addr = ^{addra[31:ADDR_BITS+2], addrb[31:ADDR_BITS+2]};

   // Byte writes; port A is applied last so it wins on a shared byte.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (web[i]) begin
            r_mem[w_idx_b][8*i +: 8] <= dinb[8*i +: 8];
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (wea[i]) begin
            r_mem[w_idx_a][8*i +: 8] <= dina[8*i +: 8];
         end
      end
   end

   // Read-first output registers; rst clears them but never the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_douta <= '0;
         r_doutb <= '0;
      end else begin
         r_douta <= r_mem[w_idx_a];
         r_doutb <= r_mem[w_idx_b];
      end
   end

   assign douta = r_douta;
   assign doutb = r_doutb;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vector table plus randomized traffic checked against
// a behavioural word-array model of the dual-port RAM.
module tb_data_ram;

   localparam int unsigned ADDR_BITS = 12;
   localparam int unsigned DEPTH     = 1 << ADDR_BITS;

   logic        clk;
   logic        rst;
   logic [3:0]  wea;
   logic [29:0] addra;
   logic [31:0] dina;
   logic [31:0] douta;
   logic [3:0]  web;
   logic [29:0] addrb;
   logic [31:0] dinb;
   logic [31:0] doutb;

   int n_checks;
   int n_fails;

   logic [31:0] model_mem [0:DEPTH-1];
   logic [31:0] pred_a;
   logic [31:0] pred_b;

   typedef struct {
      logic        rst;
      logic [3:0]  wea;
      logic [29:0] addra;
      logic [31:0] dina;
      logic [3:0]  web;
      logic [29:0] addrb;
      logic [31:0] dinb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   data_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive one cycle, clock it, and update the reference model.
   task automatic step(input logic r, input logic [3:0] wa, input logic [29:0] aa,
                       input logic [31:0] da, input logic [3:0] wb, input logic [29:0] ab,
                       input logic [31:0] db);
      int unsigned ia;
      int unsigned ib;
      rst   = r;
      wea   = wa;
      addra = aa;
      dina  = da;
      web   = wb;
      addrb = ab;
      dinb  = db;
      ia = int'(aa) % DEPTH;
      ib = int'(ab) % DEPTH;
      pred_a = r ? 32'h0 : model_mem[ia];
      pred_b = r ? 32'h0 : model_mem[ib];
      for (int k = 0; k < 4; k++) begin
         if (wb[k] && !(wa[k] && ia == ib)) model_mem[ib][8*k +: 8] = db[8*k +: 8];
         if (wa[k]) model_mem[ia][8*k +: 8] = da[8*k +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
      rst   = 1'b0;
      wea   = 4'h0;
      addra = '0;
      dina  = '0;
      web   = 4'h0;
      addrb = '0;
      dinb  = '0;

      //          rst  wea    addra  dina          web    addrb  dinb          exp_a         exp_b
      vecs[0]  = '{1'b1, 4'h0, 30'd0,  32'h0,        4'h0, 30'd0,  32'h0,        32'h0,        32'h0};
      vecs[1]  = '{1'b0, 4'hF, 30'd5,  32'hDEADBEEF, 4'h0, 30'd0,  32'h0,        32'h0,        32'h0};
      vecs[2]  = '{1'b0, 4'h0, 30'd5,  32'h0,        4'h0, 30'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 4'hF, 30'd7,  32'h11223344, 4'h0, 30'd5,  32'h0,        32'h0,        32'hDEADBEEF};
      vecs[4]  = '{1'b0, 4'h4, 30'd7,  32'hAABBCCDD, 4'h0, 30'd7,  32'h0,        32'h11223344, 32'h11223344};
      vecs[5]  = '{1'b0, 4'h0, 30'd7,  32'h0,        4'h0, 30'd7,  32'h0,        32'h11BB3344, 32'h11BB3344};
      vecs[6]  = '{1'b0, 4'hF, 30'd3,  32'h1,        4'h0, 30'd0,  32'h0,        32'h0,        32'h0};
      vecs[7]  = '{1'b0, 4'hF, 30'd3,  32'h2,        4'h0, 30'd3,  32'h0,        32'h1,        32'h1};
      vecs[8]  = '{1'b0, 4'h0, 30'd3,  32'h0,        4'h0, 30'd3,  32'h0,        32'h2,        32'h2};
      vecs[9]  = '{1'b0, 4'hF, 30'd9,  32'hA,        4'hF, 30'd9,  32'hB,        32'h0,        32'h0};
      vecs[10] = '{1'b0, 4'h0, 30'd9,  32'h0,        4'h0, 30'd9,  32'h0,        32'hA,        32'hA};
      vecs[11] = '{1'b0, 4'hF, 30'd4098, 32'h55,     4'h0, 30'd0,  32'h0,        32'h0,        32'h0};
      vecs[12] = '{1'b0, 4'h0, 30'd2,  32'h0,        4'h0, 30'd12290, 32'h0,     32'h55,       32'h55};
      vecs[13] = '{1'b1, 4'h0, 30'd2,  32'h0,        4'hF, 30'd20, 32'h77,       32'h0,        32'h0};
      vecs[14] = '{1'b0, 4'h0, 30'd2,  32'h0,        4'h0, 30'd20, 32'h0,        32'h55,       32'h77};
      vecs[15] = '{1'b0, 4'h3, 30'd30, 32'hAAAAAAAA, 4'h6, 30'd30, 32'hBBBBBBBB, 32'h0,        32'h0};
      vecs[16] = '{1'b0, 4'h0, 30'd30, 32'h0,        4'h0, 30'd30, 32'h0,        32'h00BBAAAA, 32'h00BBAAAA};

      #1;
      check("douta_before_first_edge", douta, 32'h0);
      check("doutb_before_first_edge", doutb, 32'h0);

      for (int v = 0; v < NVEC; v++) begin
         step(vecs[v].rst, vecs[v].wea, vecs[v].addra, vecs[v].dina,
              vecs[v].web, vecs[v].addrb, vecs[v].dinb);
         check($sformatf("vec%0d_douta", v), douta, vecs[v].exp_a);
         check($sformatf("vec%0d_doutb", v), doutb, vecs[v].exp_b);
      end

      // Random traffic over a small window so collisions and wraps are common.
      for (int n = 0; n < 400; n++) begin
         logic [29:0] ra;
         logic [29:0] rb;
         ra = 30'(($urandom_range(0, 3) << ADDR_BITS) | $urandom_range(0, 15));
         rb = 30'(($urandom_range(0, 3) << ADDR_BITS) | $urandom_range(0, 15));
         step(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), ra, $urandom,
              4'($urandom_range(0, 15)), rb, $urandom);
         check($sformatf("rand%0d_douta", n), douta, pred_a);
         check($sformatf("rand%0d_doutb", n), doutb, pred_b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
